// File: rtl/sha256_block_ctrl.sv
// sha256_block_ctrl: buffers 16-word blocks and sequences the SHA-256 message schedule.
// Defining SHA_CTRL_ABORT_EN adds the abort input and aborted output.
module sha256_block_ctrl #(
  parameter int BLOCK_WORDS = 16,
  parameter int ROUNDS      = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  input  logic             s_last,
`ifdef SHA_CTRL_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             s_ready,
  output logic [31:0]      ms_data,
  output logic             ms_write_enable,
  output logic             ms_inner_busy,
  output logic             round_valid,
  output logic [5:0]       round_idx,
  output logic             first_block,
  output logic             block_done,
  output logic             msg_done,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int WW = $clog2(BLOCK_WORDS + 1);
  localparam int IW = $clog2(BLOCK_WORDS);
  localparam int RW = $clog2(ROUNDS);
  localparam logic [WW-1:0] WORDS_N     = WW'(BLOCK_WORDS);
  localparam logic [WW-1:0] WORD_LAST   = WW'(BLOCK_WORDS - 1);
  localparam logic [RW-1:0] ROUND_LAST  = RW'(ROUNDS - 1);
  localparam logic [RW-1:0] LOAD_ROUNDS = RW'(BLOCK_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic             last_q, last_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [31:0]      word_buf_q [BLOCK_WORDS];

  logic [31:0]      ms_data_q, ms_data_d;
  logic             ms_we_q, ms_we_d;
  logic             ms_busy_q, ms_busy_d;
  logic             round_valid_q, round_valid_d;
  logic [5:0]       round_idx_q, round_idx_d;
  logic             first_block_q, first_block_d;
  logic             block_done_q, block_done_d;
  logic             msg_done_q, msg_done_d;
  logic             busy_q, busy_d;

  logic kill;
  logic hs;

`ifdef SHA_CTRL_ABORT_EN
  logic aborted_q, aborted_d;
  assign kill    = abort && (state_q != ST_IDLE);
  assign aborted = aborted_q;
`else
  assign kill = 1'b0;
`endif

  // Ready depends only on state and word count, so a stalled host never sees it toggle.
  assign s_ready = (state_q == ST_LOAD) && (wcnt_q < WORDS_N);
  assign hs      = s_valid && s_ready && !kill;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q       <= ST_IDLE;
      wcnt_q        <= '0;
      rcnt_q        <= '0;
      last_q        <= 1'b0;
      first_q       <= 1'b0;
      blk_cnt_q     <= '0;
      ms_data_q     <= '0;
      ms_we_q       <= 1'b0;
      ms_busy_q     <= 1'b0;
      round_valid_q <= 1'b0;
      round_idx_q   <= '0;
      first_block_q <= 1'b0;
      block_done_q  <= 1'b0;
      msg_done_q    <= 1'b0;
      busy_q        <= 1'b0;
`ifdef SHA_CTRL_ABORT_EN
      aborted_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      rcnt_q        <= rcnt_d;
      last_q        <= last_d;
      first_q       <= first_d;
      blk_cnt_q     <= blk_cnt_d;
      ms_data_q     <= ms_data_d;
      ms_we_q       <= ms_we_d;
      ms_busy_q     <= ms_busy_d;
      round_valid_q <= round_valid_d;
      round_idx_q   <= round_idx_d;
      first_block_q <= first_block_d;
      block_done_q  <= block_done_d;
      msg_done_q    <= msg_done_d;
      busy_q        <= busy_d;
`ifdef SHA_CTRL_ABORT_EN
      aborted_q     <= aborted_d;
`endif
    end
  end

  // NOTE: the word buffer has no reset; its contents are always rewritten before they are read.
  always_ff @(posedge clk) begin
    if (hs) word_buf_q[wcnt_q[IW-1:0]] <= s_data;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    last_d    = last_q;
    first_d   = first_q;
    blk_cnt_d = blk_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          wcnt_d    = '0;
          blk_cnt_d = '0;
          first_d   = 1'b1;
          last_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == WORD_LAST) begin
            last_d  = s_last;
            rcnt_d  = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == ROUND_LAST) begin
          rcnt_d  = '0;
          state_d = ST_FLUSH;
          // Counted on entry so blk_cnt moves in the same cycle block_done is shown.
          if (blk_cnt_q != '1) blk_cnt_d = blk_cnt_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (last_q) begin
          state_d = ST_IDLE;
        end else begin
          first_d = 1'b0;
          wcnt_d  = '0;
          state_d = ST_LOAD;
        end
      end
    endcase
    if (kill) begin
      state_d   = ST_IDLE;
      blk_cnt_d = blk_cnt_q;
    end
  end

  // Output logic: registered outputs are computed from the next state so they align with it.
  always_comb begin
    ms_busy_d     = (state_d == ST_RUN);
    ms_we_d       = ms_busy_d && (rcnt_d < LOAD_ROUNDS);
    ms_data_d     = ms_we_d ? word_buf_q[rcnt_d[IW-1:0]] : '0;
    round_valid_d = (ms_busy_d && (rcnt_d != '0)) || (state_d == ST_FLUSH);
    round_idx_d   = '0;
    if (state_d == ST_FLUSH)             round_idx_d = 6'(ROUND_LAST);
    else if (ms_busy_d && rcnt_d != '0) round_idx_d = 6'(rcnt_d - RW'(1));
    first_block_d = first_d && ((state_d == ST_RUN) || (state_d == ST_FLUSH));
    block_done_d  = (state_d == ST_FLUSH);
    msg_done_d    = block_done_d && last_d;
    busy_d        = (state_d != ST_IDLE);
`ifdef SHA_CTRL_ABORT_EN
    aborted_d     = kill;
`endif
  end

  assign ms_data         = ms_data_q;
  assign ms_write_enable = ms_we_q;
  assign ms_inner_busy   = ms_busy_q;
  assign round_valid     = round_valid_q;
  assign round_idx       = round_idx_q;
  assign first_block     = first_block_q;
  assign block_done      = block_done_q;
  assign msg_done        = msg_done_q;
  assign busy            = busy_q;
  assign blk_cnt         = blk_cnt_q;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Testbench for sha256_block_ctrl: drives blocks, models the external message schedule,
// and scores every tagged round against a software SHA-256 schedule.
`timescale 1ns/1ps
module tb_sha256_block_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [31:0] ms_data;
  logic        ms_write_enable;
  logic        ms_inner_busy;
  logic        round_valid;
  logic [5:0]  round_idx;
  logic        first_block;
  logic        block_done;
  logic        msg_done;
  logic        busy;
  logic [15:0] blk_cnt;
`ifdef SHA_CTRL_ABORT_EN
  logic        abort = 1'b0;
  logic        aborted;
`endif

  always #5 clk = ~clk;

  sha256_block_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .s_valid         (s_valid),
    .s_data          (s_data),
    .s_last          (s_last),
`ifdef SHA_CTRL_ABORT_EN
    .abort           (abort),
    .aborted         (aborted),
`endif
    .s_ready         (s_ready),
    .ms_data         (ms_data),
    .ms_write_enable (ms_write_enable),
    .ms_inner_busy   (ms_inner_busy),
    .round_valid     (round_valid),
    .round_idx       (round_idx),
    .first_block     (first_block),
    .block_done      (block_done),
    .msg_done        (msg_done),
    .busy            (busy),
    .blk_cnt         (blk_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [63:0] outs_vec();
    return {2'b00, s_ready, ms_data, ms_write_enable, ms_inner_busy, round_valid,
            round_idx, first_block, block_done, msg_done, busy, blk_cnt};
  endfunction

  typedef logic [31:0] blk_t [16];
  typedef struct {
    logic [5:0]  idx;
    logic [31:0] wt;
    logic        first;
    logic        bdone;
    logic        mdone;
  } exp_t;

  exp_t sb_q[$];
  logic msg_first = 1'b0;

  // Expected rounds for one block, from a software schedule computed on the words sent.
  task automatic push_block(input blk_t m, input logic last);
    logic [31:0] w [64];
    exp_t e;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = m[t];
      else        w[t] = sig1(w[t-2]) + w[t-7] + sig0(w[t-15]) + w[t-16];
      e.idx   = 6'(t);
      e.wt    = w[t];
      e.first = msg_first;
      e.bdone = (t == 63);
      e.mdone = (t == 63) && last;
      sb_q.push_back(e);
    end
    msg_first = 1'b0;
  endtask

  // External schedule model driven by ms_* plus the round monitor.
  logic [31:0] win [16];
  logic [31:0] sched_wt = '0;
  logic [31:0] wt_cap [64];
  logic        prev_valid = 1'b0;
  logic [5:0]  prev_idx = '0;
  logic        expect_cut = 1'b0;
  int          blk_done_cnt = 0;
  int          msg_done_cnt = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    logic [31:0] nw;
    if (round_valid === 1'b1) begin
      check("round_seq", round_idx, prev_valid ? prev_idx + 6'd1 : 6'd0);
      wt_cap[round_idx] = sched_wt;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL round_unexpected: got round %0d want no round", round_idx);
      end else begin
        e = sb_q.pop_front();
        check("round_idx", round_idx, e.idx);
        check("round_wt", sched_wt, e.wt);
        check("round_first", first_block, e.first);
        check("round_bdone", block_done, e.bdone);
        check("round_mdone", msg_done, e.mdone);
      end
    end else if (prev_valid && !expect_cut) begin
      check("round_end", prev_idx, 63);
    end
    if (block_done === 1'b1) begin
      blk_done_cnt++;
      check("flush_inner_busy", ms_inner_busy, 0);
    end
    if (msg_done === 1'b1) msg_done_cnt++;
    prev_valid = (round_valid === 1'b1);
    prev_idx   = round_idx;
    if (ms_inner_busy !== 1'b1) begin
      foreach (win[i]) win[i] = '0;
      sched_wt = '0;
    end else begin
      nw = ms_write_enable ? ms_data : sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
      for (int i = 0; i < 15; i++) win[i] = win[i+1];
      win[15]  = nw;
      sched_wt = nw;
    end
  end

  int gap_after [16];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    msg_first = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (s_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL send_word_timeout: got s_ready=%b want 1 within 300 cycles", s_ready);
    end else begin
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
  endtask

  task automatic send_block(input blk_t m, input logic [15:0] last_mask, input logic use_gaps);
    for (int i = 0; i < 16; i++) begin
      send_word(m[i], last_mask[i]);
      if (use_gaps) begin
        for (int g = 0; g < gap_after[i]; g++) begin
          @(negedge clk);
          check("gap_ready_hold", s_ready, 1);
        end
      end
    end
    push_block(m, last_mask[15]);
    check("run_entry", {ms_inner_busy, ms_write_enable, round_valid, s_ready, ms_data},
          {1'b1, 1'b1, 1'b0, 1'b0, m[0]});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=%b want 0 within 300 cycles", busy);
    end
  endtask

  task automatic wait_round(input logic [5:0] idx);
    int n = 0;
    while (!(round_valid === 1'b1 && round_idx == idx) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL round_timeout: got idx=%0d want %0d within 300 cycles", round_idx, idx);
    end
  endtask

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] wt;
  } vec_t;

  initial begin
    vec_t vecs [7];
    blk_t abc, b0, b1;
    int   base_m, base_b;

    vecs[0] = '{6'd0,  32'h61626380};
    vecs[1] = '{6'd1,  32'h00000000};
    vecs[2] = '{6'd14, 32'h00000000};
    vecs[3] = '{6'd15, 32'h00000018};
    vecs[4] = '{6'd16, 32'h61626380};
    vecs[5] = '{6'd17, 32'h000F0000};
    vecs[6] = '{6'd63, 32'h12B1EDEB};
    foreach (abc[i]) abc[i] = '0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    foreach (b0[i]) b0[i] = $urandom();
    foreach (b1[i]) b1[i] = $urandom();
    foreach (gap_after[i]) gap_after[i] = 0;
    foreach (wt_cap[i]) wt_cap[i] = '0;

    // Reset state
    reset = 1'b0;
    cyc(3);
    check("reset_outputs", outs_vec(), 0);
    reset = 1'b1;
    cyc(2);
    check("idle_outputs", outs_vec(), 0);

    // Single "abc" block, back-to-back words
    base_m = msg_done_cnt;
    base_b = blk_done_cnt;
    do_start();
    send_block(abc, 16'h8000, 1'b0);
    wait_idle();
    check("A_blk_cnt", blk_cnt, 1);
    check("A_msg_done", msg_done_cnt - base_m, 1);
    check("A_block_done", blk_done_cnt - base_b, 1);
    for (int i = 0; i < 7; i++) check($sformatf("A_wt_%0d", vecs[i].idx), wt_cap[vecs[i].idx], vecs[i].wt);

    // Same block with 5 stall cycles at random word positions
    foreach (wt_cap[i]) wt_cap[i] = '0;
    for (int k = 0; k < 5; k++) gap_after[$urandom_range(0, 14)]++;
    do_start();
    send_block(abc, 16'h8000, 1'b1);
    wait_idle();
    check("B_blk_cnt", blk_cnt, 1);
    for (int i = 0; i < 7; i++) check($sformatf("B_wt_%0d", vecs[i].idx), wt_cap[vecs[i].idx], vecs[i].wt);

    // Two-block message
    base_m = msg_done_cnt;
    base_b = blk_done_cnt;
    do_start();
    send_block(b0, 16'h0000, 1'b0);
    send_block(b1, 16'h8000, 1'b0);
    wait_idle();
    check("C_blk_cnt", blk_cnt, 2);
    check("C_msg_done", msg_done_cnt - base_m, 1);
    check("C_block_done", blk_done_cnt - base_b, 2);

    // start during RUN and s_last on word 3 are both ignored
    base_m = msg_done_cnt;
    do_start();
    send_block(b1, 16'h0008, 1'b0);
    wait_round(6'd10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_block(b0, 16'h8000, 1'b0);
    wait_idle();
    check("D_blk_cnt", blk_cnt, 2);
    check("D_msg_done", msg_done_cnt - base_m, 1);

    // Reset held 3 cycles at RUN r=20
    base_b = blk_done_cnt;
    do_start();
    send_block(abc, 16'h8000, 1'b0);
    wait_round(6'd19);
    expect_cut = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check("E_rst_first_edge", outs_vec(), 0);
    cyc(2);
    check("E_rst_held", outs_vec(), 0);
    reset = 1'b1;
    sb_q.delete();
    cyc(2);
    check("E_after_release", outs_vec(), 0);
    check("E_no_done", blk_done_cnt - base_b, 0);
    expect_cut = 1'b0;
    base_m = msg_done_cnt;
    do_start();
    send_block(abc, 16'h8000, 1'b0);
    wait_idle();
    check("E_recover_blk_cnt", blk_cnt, 1);
    check("E_recover_msg_done", msg_done_cnt - base_m, 1);

`ifdef SHA_CTRL_ABORT_EN
    // Abort in IDLE is ignored; abort at RUN r=30 of block 1 returns to IDLE
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("F_idle_abort", {aborted, busy}, 0);
    base_m = msg_done_cnt;
    do_start();
    send_block(b0, 16'h0000, 1'b0);
    send_block(abc, 16'h8000, 1'b0);
    wait_round(6'd29);
    base_b = blk_done_cnt;
    expect_cut = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("F_aborted_pulse", aborted, 1);
    check("F_abort_state", {busy, ms_inner_busy, ms_write_enable, s_ready, round_valid}, 0);
    check("F_blk_cnt_hold", blk_cnt, 1);
    @(negedge clk);
    check("F_aborted_end", aborted, 0);
    check("F_no_done", {blk_done_cnt - base_b, msg_done_cnt - base_m}, 0);
    sb_q.delete();
    expect_cut = 1'b0;
    do_start();
    send_block(abc, 16'h8000, 1'b0);
    wait_idle();
    check("F_restart_blk_cnt", blk_cnt, 1);
    check("F_restart_msg_done", msg_done_cnt - base_m, 1);
`endif

    cyc(2);
    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_block_ctrl.md
Name: sha256_block_ctrl

Overview:
Sequencer for the SHA-256 message schedule datapath. It accepts 512-bit blocks from the host as 16 32-bit words over a valid/ready stream and buffers each block. It then drives the schedule for exactly 64 busy cycles: 16 load cycles followed by 48 expansion cycles. It tags each resulting Wt with its round index for the hash core, and it sequences multi-block messages and flags the first block.

Parameters:
BLOCK_WORDS, 16, input words per block; fixed for SHA-256, used for counter sizing only.
ROUNDS, 64, busy cycles per block; must equal the schedule's internal wrap count.
CNT_W, 16, width of the blk_cnt block counter.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-low reset.
start  in  1  one-cycle pulse; begins a new message; honoured only in IDLE.
s_valid  in  1  host word valid.
s_data  in  32  host message word, big-endian word order, word 0 first.
s_last  in  1  sampled only with word 15 of a block; 1 = final block of the message.
s_ready  out  1  controller accepts a word this cycle.
ms_data  out  32  to schedule data input.
ms_write_enable  out  1  to schedule write_enable.
ms_inner_busy  out  1  to schedule inner_busy.
round_valid  out  1  schedule Wt output is valid for round round_idx this cycle.
round_idx  out  6  round number 0..63.
first_block  out  1  current rounds belong to block 0 of the message.
block_done  out  1  one-cycle pulse with round 63.
msg_done  out  1  one-cycle pulse with round 63 of the final block.
busy  out  1  state != IDLE.
blk_cnt  out  CNT_W  blocks completed in the current message; saturates at all-ones.

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE; all outputs 0, including s_ready, ms_*, round_idx and blk_cnt; buffer contents are don't-care.
- Reset mid-block: the next cycle has ms_inner_busy=0, which clears the schedule. No done pulses are issued.
- States: IDLE, LOAD, RUN, FLUSH.
- IDLE:
  - start -> LOAD; blk_cnt<=0; first-block flag <=1.
  - s_ready=0.
  - start while not in IDLE is ignored.
- LOAD:
  - s_ready=1 while the word count < 16.
  - Each s_valid&&s_ready handshake writes buf[wcnt] and increments wcnt.
  - The last flag is captured on the word-15 handshake.
  - After the word-15 handshake: -> RUN next cycle; s_ready drops in that same next cycle.
  - s_valid gaps stall LOAD indefinitely.
- RUN: 64 cycles, r=0..63.
  - ms_inner_busy=1 throughout.
  - ms_write_enable=1 and ms_data=buf[r] for r<16.
  - ms_write_enable=0 and ms_data=0 for r>=16.
  - After r=63 -> FLUSH.
- Round tagging: Wt is registered in the schedule, so round_valid=1 with round_idx=r-1 in RUN cycles r=1..63, and round_idx=63 in FLUSH.
  - round_valid=0 in RUN cycle 0.
  - Exactly 64 round_valid cycles per block, contiguous.
- FLUSH: 1 cycle.
  - ms_inner_busy=0; this guarantees at least one idle cycle between blocks so the schedule's counter and registers clear.
  - block_done=1; blk_cnt increments, saturating.
  - If the last flag is set: msg_done=1 -> IDLE.
  - Otherwise: first-block flag <=0; wcnt<=0 -> LOAD.
- first_block: valid during RUN and FLUSH of block 0; 0 otherwise.
- Outputs are registered except s_ready. s_ready is a function of state and wcnt only, never of s_valid.
- A block of all-zero words is legal; the controller never inspects data.
- ROUNDS cycles in RUN plus one FLUSH cycle gives a minimum block period of 16+64+1=81 cycles with a back-to-back host.

Optional Feature:
SHA_CTRL_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit, one-cycle pulse).
  - abort=1 in any non-IDLE state -> IDLE next cycle, with ms_inner_busy=0, ms_write_enable=0 and s_ready=0.
  - No block_done or msg_done is issued; aborted=1 for one cycle; blk_cnt holds its value.
  - abort in IDLE is ignored, and aborted stays 0.
  - abort has priority over start and over a simultaneous handshake, so the word is not accepted.
- Undefined: neither port exists, and behaviour is as described above.

Test Plan:
- Reset held 3 cycles mid-RUN (r=20), then released -> all outputs 0 from the first reset edge; the schedule sees inner_busy=0; no block_done.
- start, then words 0x61626380, 0x0 x14, 0x00000018 with s_last=1 on word 15, no gaps -> RUN 1 cycle after word 15; round_valid 64 contiguous cycles, idx 0..63; the schedule's Wt at idx 16 = 0x61626380, idx 63 = 0x12B1EDEB; block_done and msg_done together; blk_cnt=1; IDLE.
- Same block with s_valid low for 5 random cycles during LOAD -> s_ready is held; 16 words are buffered in order; identical round outputs.
- Two-block message, s_last=0 then 1 -> first_block=1 only for block 0; one FLUSH cycle with inner_busy=0 between the two RUNs; msg_done only on block 1; blk_cnt=2.
- start pulsed during RUN, and s_last=1 on word 3 -> both ignored; block finishes normally; message continues to a second block.
- SHA_CTRL_ABORT_EN defined: abort at RUN r=30 -> IDLE next cycle; aborted pulse; no done pulses; a new start then completes normally.
